// File: rtl/vartheta_seq.sv
// Column-serial SWAN vartheta layer: rotates the four columns of a half-state one per cycle.
// Define VARTHETA_SEQ_FAST_EN to rotate all four columns combinationally on the accepting edge.
module vartheta_seq #(
    parameter int SIDE_SIZE   = 128,
    parameter int COLUMN_SIZE = SIDE_SIZE / 4,
    parameter int PA          = 1,
    parameter int PB          = 9,
    parameter int PC          = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 inv,
    input  logic [0:SIDE_SIZE-1] x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:SIDE_SIZE-1] y,
    output logic                 busy
);

    function automatic int col_amount(input int k);
        case (k)
            0:       return PC;
            1:       return PB;
            2:       return PA;
            default: return 0;
        endcase
    endfunction

    // Rotating a doubled column avoids zero-width slices when the amount is 0.
    function automatic logic [0:SIDE_SIZE-1] rotate_word(input logic [0:SIDE_SIZE-1] w,
                                                         input logic inverse);
        logic [0:SIDE_SIZE-1]     r;
        logic [2*COLUMN_SIZE-1:0] dbl;
        r = w;
        for (int k = 0; k < 4; k++) begin
            dbl = {w[k*COLUMN_SIZE +: COLUMN_SIZE], w[k*COLUMN_SIZE +: COLUMN_SIZE]};
            if (inverse) begin
                dbl = dbl << col_amount(k);
                r[k*COLUMN_SIZE +: COLUMN_SIZE] = dbl[2*COLUMN_SIZE-1 -: COLUMN_SIZE];
            end else begin
                dbl = dbl >> col_amount(k);
                r[k*COLUMN_SIZE +: COLUMN_SIZE] = dbl[COLUMN_SIZE-1:0];
            end
        end
        return r;
    endfunction

    logic [0:SIDE_SIZE-1] data_q, data_d;
    logic                 accept;

    assign accept = in_valid && in_ready;
    assign y      = data_q;

`ifdef VARTHETA_SEQ_FAST_EN

    logic valid_q, valid_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign busy      = 1'b0;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            data_d  = rotate_word(x, inv);
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data register is reset because y must read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`else

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_e;

    state_e               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [0:SIDE_SIZE-1] rot_all;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ROT);

    // All columns are rotated here; only column cnt_q is written back each cycle.
    assign rot_all = rotate_word(data_q, mode_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = x;
                    mode_d  = inv;
                    cnt_d   = 2'd0;
                    state_d = ROT;
                end
            end
            ROT: begin
                for (int k = 0; k < 4; k++) begin
                    if (cnt_q == 2'(k)) begin
                        data_d[k*COLUMN_SIZE +: COLUMN_SIZE] = rot_all[k*COLUMN_SIZE +: COLUMN_SIZE];
                    end
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (in_valid) begin
                        data_d  = x;
                        mode_d  = inv;
                        cnt_d   = 2'd0;
                        state_d = ROT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the data register is reset because y must read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

`endif

endmodule

// File: tb/tb_vartheta_seq.sv
// Self-checking bench for vartheta_seq: default instance plus a 64-bit instance with a zero rotation.
// Expectations come from a per-bit index model of the column rotations.
module tb_vartheta_seq;

    localparam int SA = 128;
    localparam int SB = 64;

`ifdef VARTHETA_SEQ_FAST_EN
    // Edges after the accept edge until out_valid, busy cycles, and cycles between outputs.
    localparam int EXP_LAT  = 0;
    localparam int EXP_BUSY = 0;
    localparam int EXP_GAP  = 1;
`else
    localparam int EXP_LAT  = 4;
    localparam int EXP_BUSY = 4;
    localparam int EXP_GAP  = 5;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, inv, out_valid, out_ready, busy;
    logic [0:SA-1] x, y;
    logic          in_valid_b, in_ready_b, inv_b, out_valid_b, out_ready_b, busy_b;
    logic [0:SB-1] x_b, y_b;

    vartheta_seq dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
        .x(x), .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    vartheta_seq #(.SIDE_SIZE(SB), .PA(0), .PB(3), .PC(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .inv(inv_b),
        .x(x_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .y(y_b), .busy(busy_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Column k numeric bit j lives at index k*c + (c-1-j); right rotation by p
    // takes bit j from bit (j+p) mod c, left rotation from bit (j-p) mod c.
    function automatic logic [0:127] model(input logic [0:127] w, input logic iv,
                                           input int side, input int pa, input int pb, input int pc);
        logic [0:127] r;
        int c, p, src;
        r = '0;
        c = side / 4;
        for (int k = 0; k < 4; k++) begin
            p = (k == 0) ? pc : (k == 1) ? pb : (k == 2) ? pa : 0;
            for (int j = 0; j < c; j++) begin
                src = iv ? (j - p + c) % c : (j + p) % c;
                r[k*c + (c-1-j)] = w[k*c + (c-1-src)];
            end
        end
        return r;
    endfunction

    function automatic logic [0:127] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Entered on the negedge right after the accepting edge.
    task automatic wait_result(output logic [0:127] res, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check("res_valid", 128'(out_valid), 128'(1'b1));
        res = y;
    endtask

    // Entered on a negedge with dut_a idle; leaves it idle again.
    task automatic run_a(input logic [0:127] w, input logic iv,
                         output logic [0:127] res, output int lat, output int bcnt);
        in_valid  = 1'b1;
        x         = w;
        inv       = iv;
        out_ready = 1'b0;
        #1 check("acc_rdy", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        x        = rand_word();
        inv      = ~iv;
        wait_result(res, lat, bcnt);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [0:127] w, w2, res, back, expw;
    logic         iv;
    int           lat, bcnt;
    logic [0:63]  qb[$];
    int           hs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b0;
        inv_b       = 1'b0;
        x_b         = '0;
        // Reset held with random input activity.
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom());
            out_ready = 1'($urandom());
            inv       = 1'($urandom());
            x         = rand_word();
            @(negedge clk);
            check("rst_rdy", 128'(in_ready), 128'(1'b1));
            check("rst_ov", 128'(out_valid), 128'(1'b0));
            check("rst_busy", 128'(busy), 128'(1'b0));
            check("rst_y", y, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Directed forward and inverse vectors.
        w    = 128'h00000001_00000001_00000001_00000001;
        expw = 128'h00002000_00800000_80000000_00000001;
        run_a(w, 1'b0, res, lat, bcnt);
        check("fwd_vec", res, expw);
        check("fwd_lat", 128'(lat), 128'(EXP_LAT));
        check("fwd_busy", 128'(bcnt), 128'(EXP_BUSY));
        run_a(expw, 1'b1, res, lat, bcnt);
        check("inv_vec", res, w);
        check("inv_lat", 128'(lat), 128'(EXP_LAT));

        // Random forward/inverse round trips.
        for (int i = 0; i < 1000; i++) begin
            w = rand_word();
            run_a(w, 1'b0, res, lat, bcnt);
            check("rnd_fwd", res, model(w, 1'b0, SA, 1, 9, 19));
            run_a(res, 1'b1, back, lat, bcnt);
            check("rnd_rt", back, w);
        end

        // Backpressure in DONE, then a same-edge handoff to a new word.
        w  = rand_word();
        iv = 1'($urandom());
        in_valid = 1'b1;
        x        = w;
        inv      = iv;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(res, lat, bcnt);
        check("bp_res", res, model(w, iv, SA, 1, 9, 19));
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'($urandom());
            x         = rand_word();
            inv       = 1'($urandom());
            out_ready = 1'b0;
            #1 check("bp_rdy", 128'(in_ready), 128'(1'b0));
            @(negedge clk);
            check("bp_y", y, res);
            check("bp_ov", 128'(out_valid), 128'(1'b1));
        end
        w2        = rand_word();
        iv        = 1'($urandom());
        in_valid  = 1'b1;
        x         = w2;
        inv       = iv;
        out_ready = 1'b1;
        #1 check("bp_rdy2", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = rand_word();
        wait_result(res, lat, bcnt);
        check("bp_next", res, model(w2, iv, SA, 1, 9, 19));
        check("bp_lat", 128'(lat), 128'(EXP_LAT));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle while a result is held.
        w = rand_word();
        in_valid = 1'b1;
        x        = w;
        inv      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(res, lat, bcnt);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ov", 128'(out_valid), 128'(1'b0));
        check("arst_y", y, 128'd0);
        check("arst_rdy", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef VARTHETA_SEQ_FAST_EN
        // Reset while the third column is being rotated.
        w = rand_word();
        in_valid = 1'b1;
        x        = w;
        inv      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy0", 128'(busy), 128'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_busy", 128'(busy), 128'(1'b0));
        check("mid_y", y, 128'd0);
        check("mid_rdy", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
        w  = rand_word();
        iv = 1'($urandom());
        run_a(w, iv, res, lat, bcnt);
        check("post_rst", res, model(w, iv, SA, 1, 9, 19));

        // Continuous streaming on the 64-bit instance with a scoreboard.
        for (int cyc = 0; cyc < 60; cyc++) begin
            in_valid_b  = (cyc < 40);
            w           = rand_word();
            x_b         = w[0:63];
            inv_b       = 1'($urandom());
            out_ready_b = 1'b1;
            #1;
            if (out_valid_b && out_ready_b) begin
                check("strm_q", 128'(qb.size() != 0), 128'(1'b1));
                if (qb.size() != 0) check("strm_y", 128'(y_b), 128'(qb.pop_front()));
                hs.push_back(cyc);
            end
            if (in_valid_b && in_ready_b) begin
                expw = model(w, inv_b, SB, 0, 3, 15);
                qb.push_back(expw[0:63]);
            end
            @(negedge clk);
        end
        check("strm_left", 128'(qb.size()), 128'd0);
        check("strm_cnt", 128'(hs.size() >= 40 / EXP_GAP), 128'(1'b1));
        for (int i = 1; i < hs.size(); i++) begin
            check("strm_gap", 128'(hs[i] - hs[i-1]), 128'(EXP_GAP));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vartheta_seq.md
Name: vartheta_seq

Overview:
- Column-serial, handshaked successor to the combinational column-rotation layer of the SWAN round.
- Splits a SIDE_SIZE half-state into four COLUMN_SIZE columns and rotates one column per cycle by a per-column amount (PC, PB, PA, 0 for columns 0..3).
- Adds a runtime inverse mode for the decryption datapath.
- Sits between the round-function register and the mixing layer in area-optimised SWAN cores; all widths and rotation amounts are parametrised.

Parameters:
- SIDE_SIZE, 128: half-state width in bits; must be divisible by 4.
- COLUMN_SIZE, SIDE_SIZE/4: width of one column.
- PA, 1: rotation amount for column 2; 0 <= PA < COLUMN_SIZE.
- PB, 9: rotation amount for column 1; same range.
- PC, 19: rotation amount for column 0; same range.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word x is valid.
- in_ready  out  1  block can accept x this cycle.
- inv  in  1  0 = forward rotation, 1 = inverse; sampled on accept.
- x  in  [0:SIDE_SIZE-1]  input half-state; index 0 is the MSB; column k = x[k*COLUMN_SIZE +: COLUMN_SIZE].
- out_valid  out  1  y holds a completed result.
- out_ready  in  1  downstream consumes y.
- y  out  [0:SIDE_SIZE-1]  rotated half-state, same column layout as x.
- busy  out  1  high in ROT state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, data register=0, mode register=0.
  - in_ready=1 once reset releases; out_valid=0, busy=0, y=0.
- States: IDLE, ROT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register x and inv, cnt<=0, go to ROT.
- ROT:
  - in_ready=0, busy=1.
  - Each cycle, column cnt of the data register is replaced by its rotated value; other columns are held.
  - cnt increments each cycle. When cnt==3 the step completes, the state goes to DONE and cnt returns to 0.
  - Column 3 (amount 0) still occupies one cycle, so the schedule is fixed.
- Rotation rule:
  - Forward: numeric rotate right by P. Using [0:N-1] indexing this is {a[N-P:N-1], a[0:N-P-1]}.
  - Inverse: numeric rotate left by P.
  - P=0 is identity and must elaborate without zero-width slices.
- DONE:
  - out_valid=1; y = data register, held stable until out_valid&out_ready.
  - in_ready = out_ready in DONE (back-to-back allowed).
  - Handshake with no new input: go to IDLE, out_valid=0.
  - Handshake with simultaneous accept: load new x/inv, go to ROT.
- Latency: 4 clock edges from the accepting edge to out_valid high. Throughput: one word per 5 cycles with continuous streaming.
- y is driven only from the register, with no combinational path from x to y.
- in_valid while not ready is ignored; the source holds x.
- Changing inv mid-operation has no effect (it was sampled on accept).
- Reset asserted mid-ROT or in DONE aborts immediately to the reset values; the partial result is discarded.
- Forward followed by inverse on the same word returns the original word for any parameter set.

Optional Feature:
- Macro VARTHETA_SEQ_FAST_EN.
- Defined:
  - ROT state is removed; all four columns are rotated combinationally and registered on the accepting edge.
  - out_valid is high 1 edge after accept; busy is tied to 0.
  - Throughput is 1 word/cycle: in_ready = !out_valid | out_ready.
- Undefined: serial behaviour as above.
- Port list is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, busy=0, y=0; assert rst_n asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Forward, default params: x=0x00000001_00000001_00000001_00000001, inv=0 -> after 4 edges y=0x00002000_00800000_80000000_00000001, busy high for exactly 4 cycles.
- Inverse: x=0x00002000_00800000_80000000_00000001, inv=1 -> y=0x00000001_00000001_00000001_00000001; 1000 random words forward then inverse -> identity.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while changing in_valid/x -> y stable, in_ready=0; raise out_ready with in_valid=1 -> new word accepted that same edge.
- Reset mid-ROT: drop rst_n at cnt=2 -> state IDLE, y=0; next word processes correctly.
- Params SIDE_SIZE=64, PA=0, PB=3, PC=15, both with and without VARTHETA_SEQ_FAST_EN -> results match a bitwise software model; FAST build shows 1-cycle latency and 1 word/cycle streaming.
